// File: rtl/gpio_ctrl_if.sv
// AHB-Lite slave-side bus bundle for gpio_ctrl.
// The master modport is the fabric side; the slave modport is the GPIO block side.
interface gpio_ctrl_if;
    logic        HSEL;
    logic [7:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/gpio_ctrl.sv
// AHB-Lite GPIO controller: output/direction registers, synchronised inputs, edge IRQ.
// Optional per-pin input debounce is enabled by defining GPIO_CTRL_DEBOUNCE_EN.
module gpio_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    gpio_ctrl_if.slave       ahb,
    input  logic [WIDTH-1:0] io_in,
    output logic [WIDTH-1:0] io_out,
    output logic [WIDTH-1:0] io_in_not_out,
    output logic             irq_o
);
    localparam logic [2:0] OFF_DATAIN  = 3'd0;
    localparam logic [2:0] OFF_DATAOUT = 3'd1;
    localparam logic [2:0] OFF_DIR     = 3'd2;
    localparam logic [2:0] OFF_IE      = 3'd3;
    localparam logic [2:0] OFF_EDGE    = 3'd4;
    localparam logic [2:0] OFF_IS      = 3'd5;
    localparam logic [2:0] OFF_DBCNT   = 3'd6;

    logic             vld_p1;
    logic             wr_p1;
    logic [2:0]       addr_p1;
    logic             accept;
    logic             wr_en;
    logic [WIDTH-1:0] wdata;

    logic [WIDTH-1:0] dataout_r;
    logic [WIDTH-1:0] dir_r;
    logic [WIDTH-1:0] ie_r;
    logic [WIDTH-1:0] edge_r;
    logic [WIDTH-1:0] is_r;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] filt_d;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] is_set;
    logic [WIDTH-1:0] is_clr;
    logic [15:0]      dbcnt_rd;
    logic [31:0]      rdata;

    assign accept = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    assign wr_en  = vld_p1 & wr_p1;
    assign wdata  = ahb.HWDATA[WIDTH-1:0];

    // Address phase -> data phase
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            vld_p1  <= 1'b0;
            wr_p1   <= 1'b0;
            addr_p1 <= 3'd0;
        end else begin
            vld_p1  <= accept;
            wr_p1   <= ahb.HWRITE;
            addr_p1 <= ahb.HADDR[4:2];
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dataout_r <= '0;
            dir_r     <= '1;
            ie_r      <= '0;
            edge_r    <= '0;
        end else if (wr_en) begin
            case (addr_p1)
                OFF_DATAOUT: dataout_r <= wdata;
                OFF_DIR:     dir_r     <= wdata;
                OFF_IE:      ie_r      <= wdata;
                OFF_EDGE:    edge_r    <= wdata;
                default:     ;
            endcase
        end
    end

    // Pad input -> sync1 -> sync2
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io_in;
            sync2 <= sync1;
        end
    end

`ifdef GPIO_CTRL_DEBOUNCE_EN
    logic [15:0] dbcnt_r;
    logic [15:0] dbc [WIDTH];

    // sync2 -> filt: a pin must disagree with filt for DBCNT+1 cycles before it is accepted
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dbcnt_r <= '0;
            filt    <= '0;
            for (int i = 0; i < WIDTH; i++) dbc[i] <= '0;
        end else begin
            if (wr_en && addr_p1 == OFF_DBCNT) dbcnt_r <= ahb.HWDATA[15:0];
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == filt[i]) begin
                    dbc[i] <= '0;
                end else if (dbc[i] >= dbcnt_r) begin
                    filt[i] <= sync2[i];
                    dbc[i]  <= '0;
                end else begin
                    dbc[i] <= dbc[i] + 16'd1;
                end
            end
        end
    end

    assign dbcnt_rd = dbcnt_r;
`else
    assign filt     = sync2;
    assign dbcnt_rd = 16'd0;
`endif

    // filt -> filt_d, edge status
    assign rise   = filt & ~filt_d;
    assign fall   = ~filt & filt_d;
    assign is_set = (edge_r & rise) | (~edge_r & fall);
    assign is_clr = (wr_en && addr_p1 == OFF_IS) ? wdata : '0;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            filt_d <= '0;
            is_r   <= '0;
        end else begin
            filt_d <= filt;
            // a new event wins over a same-cycle W1C
            is_r   <= (is_r & ~is_clr) | is_set;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (vld_p1 && !wr_p1) begin
            case (addr_p1)
                OFF_DATAIN:  rdata = 32'(filt);
                OFF_DATAOUT: rdata = 32'(dataout_r);
                OFF_DIR:     rdata = 32'(dir_r);
                OFF_IE:      rdata = 32'(ie_r);
                OFF_EDGE:    rdata = 32'(edge_r);
                OFF_IS:      rdata = 32'(is_r);
                OFF_DBCNT:   rdata = 32'(dbcnt_rd);
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign ahb.HRDATA    = rdata;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;

    assign io_out        = dataout_r;
    assign io_in_not_out = dir_r;
    assign irq_o         = |(is_r & ie_r);

    logic unused;
    assign unused = &{1'b0, ahb.HADDR[7:5], ahb.HADDR[1:0], ahb.HTRANS[0], ahb.HWDATA};
endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl; read expectations are queued at the address phase
// and compared in the data phase.
module tb_gpio_ctrl;
    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] io_in;
    wire  [7:0] io_out;
    wire  [7:0] io_dir;
    wire        irq;

    always #5 clk = ~clk;

    gpio_ctrl_if bus();

    gpio_ctrl #(.WIDTH(8)) dut (
        .HCLK          (clk),
        .HRESETn       (rstn),
        .ahb           (bus),
        .io_in         (io_in),
        .io_out        (io_out),
        .io_in_not_out (io_dir),
        .irq_o         (irq)
    );

`ifdef GPIO_CTRL_DEBOUNCE_EN
    localparam int XLAT = 1;
`else
    localparam int XLAT = 0;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];
    logic        pend_rd = 1'b0;
    logic [31:0] pend_wd = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus clock: finish the previous data phase, start a new address phase.
    task automatic cycle(input logic sel, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [31:0] exp, input string tag);
        string       t;
        logic [31:0] e;
        bus.HWDATA = pend_wd;
        if (pend_rd) begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            check(t, bus.HRDATA, e);
        end
        bus.HSEL   = sel;
        bus.HTRANS = sel ? 2'b10 : 2'b00;
        bus.HWRITE = wr;
        bus.HADDR  = addr;
        pend_rd    = sel && !wr;
        pend_wd    = (sel && wr) ? wd : 32'h0;
        if (pend_rd) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_wr(input logic [7:0] addr, input logic [31:0] data);
        cycle(1'b1, 1'b1, addr, data, 32'h0, "");
    endtask

    task automatic bus_rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        cycle(1'b1, 1'b0, addr, 32'h0, exp, tag);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 8'h00, 32'h0, 32'h0, "");
    endtask

    initial begin
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWRITE = 1'b0;
        bus.HADDR  = 8'h00;
        bus.HWDATA = 32'h0;
        bus.HREADY = 1'b1;
        io_in      = 8'h00;
        rstn       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dir_pins", {24'h0, io_dir}, 32'hFF);
        check("rst_out_pins", {24'h0, io_out}, 32'h00);
        check("rst_irq", {31'h0, irq}, 32'h0);
        check("rst_hrdata", bus.HRDATA, 32'h0);
        rstn = 1'b1;

        // Reset values of every offset, including DBCNT and one unmapped slot
        bus_rd(8'h00, 32'h00, "rst_datain");
        bus_rd(8'h04, 32'h00, "rst_dataout");
        bus_rd(8'h08, 32'hFF, "rst_dir");
        bus_rd(8'h0C, 32'h00, "rst_ie");
        bus_rd(8'h10, 32'h00, "rst_edge");
        bus_rd(8'h14, 32'h00, "rst_is");
        bus_rd(8'h18, 32'h00, "rst_dbcnt");
        bus_rd(8'h1C, 32'h00, "rst_unmapped");
        idle();
        check("hreadyout", {31'h0, bus.HREADYOUT}, 32'h1);
        check("hresp", {31'h0, bus.HRESP}, 32'h0);

        // Output drive, back-to-back
        bus_wr(8'h08, 32'h0000_00F0);
        bus_wr(8'h04, 32'h0000_005A);
        bus_rd(8'h08, 32'hF0, "dir_rd");
        bus_rd(8'h04, 32'h5A, "dataout_rd");
        idle();
        check("dir_pins", {24'h0, io_dir}, 32'hF0);
        check("out_pins", {24'h0, io_out}, 32'h5A);
        bus_wr(8'h04, 32'hFFFF_FFFF);
        bus_rd(8'h04, 32'hFF, "dataout_upper_zero");
        idle();
        check("out_pins_ff", {24'h0, io_out}, 32'hFF);

        // Rising-edge interrupt on pin 0
        bus_wr(8'h10, 32'h01);
        bus_wr(8'h0C, 32'h01);
        idle();
        check("irq_idle", {31'h0, irq}, 32'h0);
        io_in[0] = 1'b1;
        idle();
        repeat (XLAT) idle();
        bus_rd(8'h00, 32'h01, "datain_rise");
        bus_rd(8'h14, 32'h01, "is_rise");
        idle();
        check("irq_rise", {31'h0, irq}, 32'h1);
        bus_wr(8'h14, 32'h01);
        bus_rd(8'h14, 32'h00, "is_w1c");
        check("irq_w1c", {31'h0, irq}, 32'h0);
        idle();

        // Falling edge on pin 3 lands on the same edge as a W1C of bit 3
        io_in[3] = 1'b1;
        repeat (5 + XLAT) idle();
        bus_rd(8'h14, 32'h00, "is_no_rise_pin3");
        idle();
        io_in[3] = 1'b0;
        idle();
        repeat (XLAT) idle();
        bus_wr(8'h14, 32'h08);
        bus_rd(8'h14, 32'h08, "is_collide");
        idle();
        check("irq_masked", {31'h0, irq}, 32'h0);
        bus_wr(8'h14, 32'h08);
        bus_rd(8'h14, 32'h00, "is_clear_pin3");
        idle();

`ifdef GPIO_CTRL_DEBOUNCE_EN
        bus_wr(8'h18, 32'd10);
        bus_rd(8'h18, 32'd10, "dbcnt_rd");
        idle();
        io_in[1] = 1'b1;
        repeat (5) idle();
        io_in[1] = 1'b0;
        repeat (20) idle();
        bus_rd(8'h00, 32'h01, "db_glitch");
        bus_rd(8'h14, 32'h00, "db_is");
        idle();
        io_in[1] = 1'b1;
        repeat (11) idle();
        bus_rd(8'h00, 32'h01, "db_before");
        bus_rd(8'h00, 32'h03, "db_after");
        idle();
`endif

        // Reset during the data phase of a DATAOUT write
        bus_wr(8'h04, 32'h0000_00FF);
        bus.HWDATA = 32'h0000_00FF;
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        rstn       = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn    = 1'b1;
        pend_rd = 1'b0;
        pend_wd = 32'h0;
        bus_rd(8'h04, 32'h00, "rst_mid_dataout");
        bus_rd(8'h08, 32'hFF, "rst_mid_dir");
        idle();
        check("rst_mid_out_pins", {24'h0, io_out}, 32'h00);
        check("rst_mid_irq", {31'h0, irq}, 32'h0);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
